calc_datapath: RTL and testbench

CALC_DATAPATH -- requirements
Module: calc_datapath

---
 rtl/calc_pkg.sv | 23 ++
 rtl/bin2bcd.sv | 74 +++++++
 rtl/calc_datapath.sv | 155 +++++++++++++++
 tb/tb_calc_datapath.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator datapath: FSM state
// encoding, operation encodings and default operand/BCD sizes.
package calc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_CONV = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_BCD_DIGITS = 5;

    // Width of a counter that must be able to hold the value n.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bin2bcd.sv
// Sequential double-dabble converter. A start pulse loads the binary
// value; one adjust-and-shift step runs per cycle for BIN_W cycles.
// done_o is high during the final step, on whose edge bcd_o updates.
module bin2bcd
    import calc_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [BIN_W-1:0]      bin_i,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  done_o
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = cnt_w(BIN_W);

    logic [BIN_W-1:0] bin_q;
    logic [BCD_W-1:0] work_q;
    logic [BCD_W-1:0] bcd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             last_w;

    // One double-dabble step: add 3 to every digit >= 5, then shift in msb.
    function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] w,
                                                 input logic msb);
        logic [BCD_W-1:0] adj;
        adj = w;
        for (int d = 0; d < DIGITS; d++) begin
            if (adj[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
        end
        return {adj[BCD_W-2:0], msb};
    endfunction

    assign last_w = busy_q && (cnt_q == CNT_W'(BIN_W - 1));
    assign done_o = last_w;
    assign bcd_o  = bcd_q;

    // Conversion sequencer: load on start, shift while busy, publish at the end.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            bin_q  <= '0;
            work_q <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (!rst_n) begin
            bin_q  <= '0;
            work_q <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            bin_q  <= bin_i;
            work_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            work_q <= dd_step(work_q, bin_q[BIN_W-1]);
            bin_q  <= bin_q << 1;
            cnt_q  <= cnt_q + 1'b1;
            if (last_w) begin
                busy_q <= 1'b0;
                bcd_q  <= dd_step(work_q, bin_q[BIN_W-1]);
            end
        end
    end

endmodule

// File: rtl/calc_datapath.sv
// Calculator datapath: operand registers, add / shift-add multiply,
// BCD conversion via bin2bcd, and a registered display word.
// Operands are snapshotted on an accepted start so later loads cannot
// disturb a running operation.
module calc_datapath
    import calc_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int BCD_DIGITS = DEF_BCD_DIGITS
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    rst_n,
    input  logic                    loadA_n,
    input  logic                    loadB_n,
    input  logic                    loadZ_n,
    input  logic                    loadOU_n,
    input  logic                    IUAU,
    input  logic                    fn,
    input  logic [WIDTH-1:0]        sw,
    output logic [2*WIDTH-1:0]      result,
    output logic [4*BCD_DIGITS-1:0] bcd,
    output logic                    busy,
    output logic                    done,
    output logic [2*WIDTH-1:0]      disp
);
    localparam int RES_W = 2 * WIDTH;
    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int MC_W  = cnt_w(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [RES_W-1:0] mcand_q, mcand_d;
    logic [RES_W-1:0] result_q, result_d;
    logic [RES_W-1:0] disp_q;
    logic [MC_W-1:0]  mcnt_q, mcnt_d;
    logic             loadz_prev_q;
    logic             start_w, accept_w, mul_last_w;
    logic             conv_start_w, conv_done_w;
    logic [BCD_W-1:0] bcd_w;

    // A start is a 1->0 transition of loadZ_n, honoured only when not busy.
    assign start_w    = loadz_prev_q && !loadZ_n;
    assign accept_w   = start_w && (state_q == ST_IDLE || state_q == ST_DONE);
    assign mul_last_w = (state_q == ST_MUL) && (mcnt_q == MC_W'(WIDTH - 1));
    // Converter is loaded with the value the result register is about to hold.
    assign conv_start_w = (accept_w && fn == OP_ADD) || mul_last_w;

    // FSM state register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            state_q <= ST_IDLE;
        else if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (accept_w) state_d = (fn == OP_MUL) ? ST_MUL : ST_CONV;
            ST_MUL:           if (mul_last_w) state_d = ST_CONV;
            ST_CONV:          if (conv_done_w) state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q == ST_MUL) || (state_q == ST_CONV);
        done = (state_q == ST_DONE);
    end

    // Arithmetic next-state: snapshot on start, one shift-add step per MUL cycle.
    always_comb begin
        result_d = result_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        mcnt_d   = mcnt_q;
        if (accept_w) begin
            if (fn == OP_MUL) begin
                result_d = '0;
                mcand_d  = {{WIDTH{1'b0}}, a_q};
                mplier_d = b_q;
                mcnt_d   = '0;
            end else begin
                result_d = {{WIDTH{1'b0}}, a_q} + {{WIDTH{1'b0}}, b_q};
            end
        end else if (state_q == ST_MUL) begin
            if (mplier_q[0])
                result_d = result_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            mcnt_d   = mcnt_q + 1'b1;
        end
    end

    // Operand, arithmetic, start-detect and display registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            mcnt_q       <= '0;
            disp_q       <= '0;
            loadz_prev_q <= 1'b1;
        end else if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            mcnt_q       <= '0;
            disp_q       <= '0;
            loadz_prev_q <= 1'b1;
        end else begin
            if (!loadA_n) a_q <= sw;
            if (!loadB_n) b_q <= sw;
            result_q     <= result_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            mcnt_q       <= mcnt_d;
            loadz_prev_q <= loadZ_n;
            if (loadOU_n)
                disp_q <= '0;
            else if (!IUAU)
                disp_q <= {a_q, b_q};
            else
                disp_q <= bcd_w[RES_W-1:0];
        end
    end

    bin2bcd #(
        .BIN_W  (RES_W),
        .DIGITS (BCD_DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .clr     (clr),
        .rst_n   (rst_n),
        .start_i (conv_start_w),
        .bin_i   (result_d),
        .bcd_o   (bcd_w),
        .done_o  (conv_done_w)
    );

    assign result = result_q;
    assign bcd    = bcd_w;
    assign disp   = disp_q;

endmodule

// File: tb/tb_calc_datapath.sv
// Directed testbench for calc_datapath with hand-computed expectations.
module tb_calc_datapath;
    localparam int WIDTH = 8;
    localparam int BCD_DIGITS = 5;

    logic                    clk = 1'b0;
    logic                    clr = 1'b1;
    logic                    rst_n = 1'b1;
    logic                    loadA_n = 1'b1, loadB_n = 1'b1, loadZ_n = 1'b1;
    logic                    loadOU_n = 1'b1, IUAU = 1'b0, fn = 1'b0;
    logic [WIDTH-1:0]        sw = '0;
    logic [2*WIDTH-1:0]      result, disp;
    logic [4*BCD_DIGITS-1:0] bcd;
    logic                    busy, done;

    int n_chk = 0;
    int n_err = 0;

    calc_datapath #(.WIDTH(WIDTH), .BCD_DIGITS(BCD_DIGITS)) dut (
        .clk(clk), .clr(clr), .rst_n(rst_n),
        .loadA_n(loadA_n), .loadB_n(loadB_n), .loadZ_n(loadZ_n),
        .loadOU_n(loadOU_n), .IUAU(IUAU), .fn(fn), .sw(sw),
        .result(result), .bcd(bcd), .busy(busy), .done(done), .disp(disp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic load_ops(input logic [7:0] a, input logic [7:0] b);
        sw = a; loadA_n = 1'b0; tick(); loadA_n = 1'b1;
        sw = b; loadB_n = 1'b0; tick(); loadB_n = 1'b1;
    endtask

    // Falling edge of loadZ_n sampled on the next edge (edge 0 of the run).
    task automatic do_start(input logic f);
        fn = f; loadZ_n = 1'b0; tick(); loadZ_n = 1'b1; fn = 1'b0;
    endtask

    initial begin
        // Asynchronous reset values
        #2 clr = 1'b0;
        #6;
        check("rst_busy",   32'(busy),   32'h0);
        check("rst_done",   32'(done),   32'h0);
        check("rst_result", 32'(result), 32'h0);
        check("rst_bcd",    32'(bcd),    32'h0);
        check("rst_disp",   32'(disp),   32'h0);
        #4 clr = 1'b1;
        tick();

        // Display of raw operands, then blanking
        load_ops(8'h12, 8'h34);
        loadOU_n = 1'b0; IUAU = 1'b0; tick();
        check("disp_ab", 32'(disp), 32'h1234);
        loadOU_n = 1'b1; tick();
        check("disp_off", 32'(disp), 32'h0);

        // 12 + 34
        load_ops(8'd12, 8'd34);
        do_start(1'b0);
        check("add_busy_e0",   32'(busy),   32'h1);
        check("add_result_e0", 32'(result), 32'd46);
        run(15);
        check("add_busy_e15", 32'(busy), 32'h1);
        check("add_done_e15", 32'(done), 32'h0);
        check("add_bcd_e15",  32'(bcd),  32'h0);
        tick();
        check("add_done_e16", 32'(done),   32'h1);
        check("add_busy_e16", 32'(busy),   32'h0);
        check("add_result",   32'(result), 32'd46);
        check("add_bcd",      32'(bcd),    32'h00046);
        loadOU_n = 1'b0; IUAU = 1'b1; tick();
        check("disp_bcd", 32'(disp), 32'h0046);
        loadOU_n = 1'b1; IUAU = 1'b0; tick();

        // 255 * 255
        load_ops(8'd255, 8'd255);
        do_start(1'b1);
        check("mul_busy_e0", 32'(busy), 32'h1);
        check("mul_done_e0", 32'(done), 32'h0);
        run(23);
        check("mul_done_e23", 32'(done), 32'h0);
        check("mul_busy_e23", 32'(busy), 32'h1);
        tick();
        check("mul_done_e24", 32'(done),   32'h1);
        check("mul_result",   32'(result), 32'd65025);
        check("mul_bcd",      32'(bcd),    32'h65025);

        // 0 * 200, then 0 + 200 restarted from DONE
        load_ops(8'd0, 8'd200);
        check("hold_done", 32'(done), 32'h1);
        do_start(1'b1);
        check("zmul_done_e0", 32'(done), 32'h0);
        run(24);
        check("zmul_done",   32'(done),   32'h1);
        check("zmul_result", 32'(result), 32'h0);
        check("zmul_bcd",    32'(bcd),    32'h0);
        do_start(1'b0);
        check("re_done_e0",  32'(done),   32'h0);
        check("re_result_e0", 32'(result), 32'd200);
        run(16);
        check("re_done",   32'(done), 32'h1);
        check("re_bcd",    32'(bcd),  32'h00200);

        // 3 * 5 with an ignored restart at edge 5 and an operand load at edge 6
        load_ops(8'd3, 8'd5);
        do_start(1'b1);
        run(4);
        fn = 1'b0; loadZ_n = 1'b0; tick(); loadZ_n = 1'b1;
        check("ign_busy_e5", 32'(busy), 32'h1);
        sw = 8'd99; loadA_n = 1'b0; tick(); loadA_n = 1'b1;
        run(17);
        check("ign_done_e23", 32'(done), 32'h0);
        tick();
        check("ign_done_e24", 32'(done),   32'h1);
        check("ign_result",   32'(result), 32'd15);
        check("ign_bcd",      32'(bcd),    32'h00015);

        // Soft reset at edge 10 of a multiply, with a load in the same cycle
        do_start(1'b1);
        run(9);
        check("sr_busy_e9", 32'(busy), 32'h1);
        rst_n = 1'b0; sw = 8'd7; loadA_n = 1'b0; tick();
        rst_n = 1'b1; loadA_n = 1'b1;
        check("sr_busy",   32'(busy),   32'h0);
        check("sr_done",   32'(done),   32'h0);
        check("sr_result", 32'(result), 32'h0);
        check("sr_bcd",    32'(bcd),    32'h0);
        loadOU_n = 1'b0; IUAU = 1'b0; tick();
        check("sr_disp_ab", 32'(disp), 32'h0);
        loadOU_n = 1'b1; tick();
        run(20);
        check("sr_stays_idle", 32'(done), 32'h0);

        // Asynchronous clear in the middle of an add
        load_ops(8'd1, 8'd2);
        do_start(1'b0);
        run(3);
        #2 clr = 1'b0;
        #1;
        check("aclr_busy",   32'(busy),   32'h0);
        check("aclr_result", 32'(result), 32'h0);
        #2 clr = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
